// File: rtl/knap_sweep_if.sv
// rtl/knap_sweep_if.sv - sweep request and result bus for knap_sweep
interface knap_sweep_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  cand;
  logic        found;
  logic [4:0]  best_sel;
  logic [31:0] best_value;
  logic [5:0]  valid_count;

  modport master (
    output start,
    input  busy, done, cand, found, best_sel, best_value, valid_count
  );

  modport slave (
    input  start,
    output busy, done, cand, found, best_sel, best_value, valid_count
  );
endinterface

// File: rtl/knap_sweep.sv
// rtl/knap_sweep.sv - exhaustive sweep of all 32 item selections, tracking the best valid one
module knap_sweep #(
  parameter logic [31:0] MIN_VALUE  = 32'd15,
  parameter logic [31:0] MAX_WEIGHT = 32'd16,
  parameter logic [31:0] MAX_VOLUME = 32'd5
) (
  input logic         clk,
  input logic         rst,
  knap_sweep_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  // Item table, index 0 = A .. index 4 = E
  localparam logic [31:0] ITEM_VALUE  [5] = '{32'd4,  32'd2, 32'd2, 32'd1, 32'd10};
  localparam logic [31:0] ITEM_WEIGHT [5] = '{32'd12, 32'd1, 32'd2, 32'd1, 32'd4};
  localparam logic [31:0] ITEM_VOLUME [5] = '{32'd1,  32'd1, 32'd1, 32'd1, 32'd1};

  state_t      state;
  logic [31:0] tot_value;
  logic [31:0] tot_weight;
  logic [31:0] tot_volume;
  logic        cand_valid;

  always_comb begin
    tot_value  = '0;
    tot_weight = '0;
    tot_volume = '0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cand[i]) begin
        tot_value  = tot_value  + ITEM_VALUE[i];
        tot_weight = tot_weight + ITEM_WEIGHT[i];
        tot_volume = tot_volume + ITEM_VOLUME[i];
      end
    end
    cand_valid = (tot_value >= MIN_VALUE) && (tot_weight <= MAX_WEIGHT) &&
                 (tot_volume <= MAX_VOLUME);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.cand        <= '0;
      bus.found       <= 1'b0;
      bus.best_sel    <= '0;
      bus.best_value  <= '0;
      bus.valid_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state           <= SWEEP;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.cand        <= '0;
            bus.found       <= 1'b0;
            bus.best_sel    <= '0;
            bus.best_value  <= '0;
            bus.valid_count <= '0;
          end
        end
        SWEEP: begin
          if (cand_valid) begin
            bus.found       <= 1'b1;
            bus.valid_count <= bus.valid_count + 6'd1;
            // Strict compare keeps the lowest candidate on ties
            if (!bus.found || (tot_value > bus.best_value)) begin
              bus.best_sel   <= bus.cand;
              bus.best_value <= tot_value;
            end
          end
          bus.cand <= bus.cand + 5'd1;
          if (bus.cand == 5'd31) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
